mux2: RTL and testbench

Registered 2-to-1 word selector for the P5 pipelined MIPS32 datapath. Each cycle it picks `in1` or `in2` under control of `sel` and captures the chosen word into an output register. This register acts as the boundary between two pipeline stages, so it supports a stall (hold) and a flush (bubble). It also records which source was taken and whether both sources were equal, for hazard and debug logic.

---
 rtl/mux2.sv | 56 +++++
 tb/tb_mux2.sv | 119 +++++++++++
 2 files changed

// File: rtl/mux2.sv
// mux2: registered 2-to-1 word selector forming a stallable/flushable pipeline boundary
module mux2 #(
    parameter int              WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel,
    input  logic             en,
    input  logic             flush,
    output logic [WIDTH-1:0] out,
    output logic             out_sel,
    output logic             out_eq
);
    logic [WIDTH-1:0] nxt;
    logic             nxt_sel;
    logic [WIDTH-1:0] out_d, out_q;
    logic             sel_d, sel_q;
    logic             eq_d, eq_q;

    // pick the source; an if (not a ternary) so an unknown sel falls to in1 instead of merging X
    always_comb begin
        nxt     = in1;
        nxt_sel = 1'b0;
        if (sel) begin
            nxt     = in2;
            nxt_sel = 1'b1;
        end
    end

    // next-state: flush beats stall, stall holds, otherwise load the selected word
    always_comb begin
        out_d = flush ? RESET_VALUE : en ? nxt : out_q;
        sel_d = flush ? 1'b0 : en ? nxt_sel : sel_q;
        eq_d  = flush ? 1'b0 : en ? (in1 == in2) : eq_q;
    end

    // stage register, cleared immediately by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= RESET_VALUE;
            sel_q <= 1'b0;
            eq_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            sel_q <= sel_d;
            eq_q  <= eq_d;
        end
    end

    assign out     = out_q;
    assign out_sel = sel_q;
    assign out_eq  = eq_q;
endmodule

// File: tb/tb_mux2.sv
// tb_mux2: scoreboard bench for the registered 2-to-1 selector
module tb_mux2;
    typedef struct {
        logic [31:0] o;
        logic        s;
        logic        e;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in1 = '0, in2 = '0;
    logic        sel = 1'b0, en = 1'b1, flush = 1'b0;
    logic [31:0] out;
    logic        out_sel, out_eq;

    exp_t q[$];
    int total = 0, bad = 0;
    logic [31:0] m_out = '0;
    logic        m_sel = 1'b0, m_eq = 1'b0;
    event async_ev;

    mux2 #(.WIDTH(32), .RESET_VALUE(32'h0)) dut (
        .clk(clk), .reset(reset), .in1(in1), .in2(in2), .sel(sel),
        .en(en), .flush(flush), .out(out), .out_sel(out_sel), .out_eq(out_eq)
    );

    always #5 clk = ~clk;

    // drive one cycle of inputs at the falling edge and queue the hand-computed result
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic e, input logic f, input logic r,
                        input logic [31:0] eo, input logic es, input logic eq, input string name);
        exp_t x;
        in1 = a; in2 = b; sel = s; en = e; flush = f; reset = r;
        x.o = eo; x.s = es; x.e = eq; x.name = name;
        q.push_back(x);
        m_out = eo; m_sel = es; m_eq = eq;
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_word();
        case ($urandom_range(0, 4))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // monitor: after each rising edge (or a mid-cycle reset) compare the oldest expectation
    initial begin
        exp_t x;
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (q.size() != 0) begin
                x = q.pop_front();
                total++;
                if (out !== x.o || out_sel !== x.s || out_eq !== x.e) begin
                    bad++;
                    $display("FAIL %s: got out=%h sel=%b eq=%b expected out=%h sel=%b eq=%b",
                             x.name, out, out_sel, out_eq, x.o, x.s, x.e);
                end
            end
        end
    end

    initial begin
        exp_t x;
        logic [31:0] a, b, eo;
        logic s, e, f, es, eq;
        @(negedge clk);
        step(32'h1111_1111, 32'h2222_2222, 1, 1, 0, 1, 32'h0, 0, 0, "rst_init");
        step(32'h1111_1111, 32'h2222_2222, 1, 1, 0, 0, 32'h2222_2222, 1, 0, "preload");
        #2 reset = 1'b1;
        x.o = 32'h0; x.s = 1'b0; x.e = 1'b0; x.name = "async_rst";
        q.push_back(x);
        -> async_ev;
        @(negedge clk);
        step(32'h1111_1111, 32'h2222_2222, 1, 1, 1, 1, 32'h0, 0, 0, "rst_hold");
        step(32'hDEAD_BEEF, 32'h1234_5678, 0, 1, 0, 0, 32'hDEAD_BEEF, 0, 0, "sel0");
        step(32'hDEAD_BEEF, 32'h1234_5678, 1, 1, 0, 0, 32'h1234_5678, 1, 0, "sel1");
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0, 0, 32'hFFFF_FFFF, 1, 1, "eq_ones");
        step(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 1, 0, 0, 32'hFFFF_FFFE, 1, 0, "neq_lsb");
        step(32'hA5A5_A5A5, 32'h0, 0, 1, 0, 0, 32'hA5A5_A5A5, 0, 0, "load_a5");
        step(32'h1, 32'h1, 1, 0, 0, 0, 32'hA5A5_A5A5, 0, 0, "stall1");
        step(32'h2, 32'h3, 0, 0, 0, 0, 32'hA5A5_A5A5, 0, 0, "stall2");
        step(32'hFFFF_FFFF, 32'h0, 1, 0, 0, 0, 32'hA5A5_A5A5, 0, 0, "stall3");
        step(32'h8000_0000, 32'h8000_0000, 1, 0, 0, 0, 32'hA5A5_A5A5, 0, 0, "stall4");
        step(32'h5, 32'h6, 0, 0, 0, 0, 32'hA5A5_A5A5, 0, 0, "stall5");
        step(32'h1, 32'h2, 1, 1, 0, 0, 32'h2, 1, 0, "stall_release");
        step(32'h0000_BEEF, 32'h0000_BEEF, 1, 1, 0, 0, 32'h0000_BEEF, 1, 1, "load_beef");
        step(32'h7, 32'h8, 1, 0, 1, 0, 32'h0, 0, 0, "flush_over_stall");
        step(32'h0000_BEEF, 32'h0000_BEEF, 1, 1, 0, 0, 32'h0000_BEEF, 1, 1, "reload_beef");
        step(32'h7, 32'h8, 1, 0, 0, 1, 32'h0, 0, 0, "reset_over_stall");
        step(32'h8000_0000, 32'h8000_0000, 0, 1, 0, 0, 32'h8000_0000, 0, 1, "msb_eq");
        step(32'h1, 32'h2, 1, 1, 1, 0, 32'h0, 0, 0, "flush_en");
        for (int i = 0; i < 100; i++) begin
            a = pick_word();
            b = ($urandom_range(0, 3) == 0) ? a : pick_word();
            s = 1'($urandom_range(0, 1));
            e = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 9) == 0);
            eo = f ? 32'h0 : !e ? m_out : s ? b : a;
            es = f ? 1'b0 : !e ? m_sel : s;
            eq = f ? 1'b0 : !e ? m_eq : (a == b);
            step(a, b, s, e, f, 0, eo, es, eq, "random");
        end
        @(negedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
